// File: rtl/soc_data_ram.sv
// soc_data_ram: word-organised RAM with byte strobes, wait states and a
// req/ready handshake. Define SOC_RAM_BOUNDS_CHECK_EN to flag out-of-range
// addresses; otherwise upper address bits are ignored and the index wraps.
module soc_data_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    writeEnable,
    input  logic [DATA_WIDTH/8-1:0] byteEnable,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   dataIn,
    output logic [DATA_WIDTH-1:0]   dataOut,
    output logic                    ready,
    output logic                    busy,
    output logic                    error
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(LANES);
    localparam int IW    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic                  we_q;
    logic [LANES-1:0]      be_q;
    logic [IW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  oor_q;

    logic [DATA_WIDTH-1:0] dout_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic                  accept;
    logic [IW-1:0]         in_idx;
    logic                  in_oor;
    logic                  do_access;
    logic                  acc_we;
    logic [LANES-1:0]      acc_be;
    logic [IW-1:0]         acc_idx;
    logic [DATA_WIDTH-1:0] acc_din;
    logic                  acc_oor;
    logic                  unused_addr;

    assign in_idx = address[OFS+IW-1:OFS];

`ifdef SOC_RAM_BOUNDS_CHECK_EN
    assign in_oor = |(address >> (OFS + IW));
`else
    assign in_oor = 1'b0;
`endif

    // Byte-offset bits (and, without bounds checking, the upper bits)
    // have no meaning for a word RAM.
    assign unused_addr = ^address;

    assign accept = req && !busy;

    // State and wait counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: wait k cycles after accept, then one response cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (accept) begin
                    cnt_d   = WS_LOAD;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        busy    = (state_q == S_WAIT);
        ready   = (state_q == S_RESP);
        dataOut = dout_q;
        error   = err_q;
    end

    // With no wait states the access happens on the accepting edge,
    // so it must use the live request rather than the latched copy.
    always_comb begin
        do_access = (state_d == S_RESP);
        if (WAIT_STATES == 0) begin
            acc_we  = writeEnable;
            acc_be  = byteEnable;
            acc_idx = in_idx;
            acc_din = dataIn;
            acc_oor = in_oor;
        end else begin
            acc_we  = we_q;
            acc_be  = be_q;
            acc_idx = idx_q;
            acc_din = din_q;
            acc_oor = oor_q;
        end
    end

    // Request capture and read/error response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q   <= 1'b0;
            be_q   <= '0;
            idx_q  <= '0;
            din_q  <= '0;
            oor_q  <= 1'b0;
            dout_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                we_q  <= writeEnable;
                be_q  <= byteEnable;
                idx_q <= in_idx;
                din_q <= dataIn;
                oor_q <= in_oor;
            end
            err_q <= do_access && acc_oor;
            if (do_access && !acc_we) begin
                dout_q <= acc_oor ? '0 : mem[acc_idx];
            end
        end
    end

    // Storage array: lane-masked write, never reset
    always_ff @(posedge clk) begin
        if (!reset && do_access && acc_we && !acc_oor) begin
            for (int i = 0; i < LANES; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][i*8 +: 8] <= acc_din[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_soc_data_ram.sv
// tb_soc_data_ram: directed checks of soc_data_ram with 0, 3 and 2 wait
// states (instances 0, 1, 2) sharing one clock and reset.
module tb_soc_data_ram;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        req  [3];
    logic        we   [3];
    logic [3:0]  be   [3];
    logic [31:0] addr [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic        rdy  [3];
    logic        bsy  [3];
    logic        err  [3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
            soc_data_ram #(
                .DATA_WIDTH (32),
                .ADDR_WIDTH (32),
                .DEPTH_WORDS(4096),
                .WAIT_STATES(WS)
            ) u_ram (
                .clk        (clk),
                .reset      (rst),
                .req        (req[g]),
                .writeEnable(we[g]),
                .byteEnable (be[g]),
                .address    (addr[g]),
                .dataIn     (din[g]),
                .dataOut    (dout[g]),
                .ready      (rdy[g]),
                .busy       (bsy[g]),
                .error      (err[g])
            );
        end
    endgenerate

    // One transaction; lat = edges after the accepting edge until ready.
    task automatic txn(input int u, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e,
                       output int lat, output logic ok);
        int n;
        n = 0;
        @(negedge clk);
        while (bsy[u] && n < 40) begin
            @(negedge clk);
            n++;
        end
        req[u] = 1'b1; we[u] = w; be[u] = b; addr[u] = a; din[u] = d;
        @(posedge clk); #1;
        req[u] = 1'b0;
        lat = 0;
        while (!rdy[u] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = rdy[u];
        rd = dout[u];
        e  = err[u];
    endtask

    task automatic test_reset();
        for (int g = 0; g < 3; g++) begin
            req[g] = 1'b0; we[g] = 1'b0; be[g] = 4'h0;
            addr[g] = 32'h0; din[g] = 32'h0;
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            total++;
            if (rdy[g] !== 1'b0 || bsy[g] !== 1'b0 || err[g] !== 1'b0) begin
                bad++;
                $display("FAIL reset_flags u%0d: rdy/bsy/err=%b%b%b want 000",
                         g, rdy[g], bsy[g], err[g]);
            end
            total++;
            if (dout[g] !== 32'h0) begin
                bad++;
                $display("FAIL reset_dout u%0d: got %h want 0", g, dout[g]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF;
        addr[0] = 32'h10; din[0] = 32'hCAFEBABE;
        @(posedge clk); #1;
        total++;
        if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_wr_resp: rdy=%b bsy=%b want 1 0", rdy[0], bsy[0]);
        end
        we[0] = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rdy[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_rd_ready: got %b want 1", rdy[0]);
        end
        total++;
        if (dout[0] !== 32'hCAFEBABE) begin
            bad++;
            $display("FAIL b2b_rd_data: got %h want cafebabe", dout[0]);
        end
        req[0] = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rdy[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: rdy=%b want 0", rdy[0]);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        logic e, ok;
        int lat;
        txn(0, 1'b1, 4'hF, 32'h20, 32'h11223344, rd, e, lat, ok);
        total++;
        if (ok !== 1'b1 || lat != 0) begin
            bad++;
            $display("FAIL lanes_wr1: ok=%b lat=%0d want 1 0", ok, lat);
        end
        txn(0, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD, rd, e, lat, ok);
        total++;
        if (rd !== 32'hCAFEBABE) begin
            bad++;
            $display("FAIL lanes_wr_dout_hold: got %h want cafebabe", rd);
        end
        txn(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, e, lat, ok);
        total++;
        if (ok !== 1'b1 || rd !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL lanes_rd: ok=%b got %h want 11bb33dd", ok, rd);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic e, ok;
        int lat;
        txn(1, 1'b1, 4'hF, 32'h10, 32'h5A5A0001, rd, e, lat, ok);
        total++;
        if (ok !== 1'b1 || lat != 3) begin
            bad++;
            $display("FAIL ws3_wr_lat: ok=%b lat=%0d want 1 3", ok, lat);
        end
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bsy[1] !== 1'b1 || rdy[1] !== 1'b0) begin
                bad++;
                $display("FAIL ws3_busy%0d: bsy=%b rdy=%b want 1 0",
                         i, bsy[1], rdy[1]);
            end
            @(posedge clk); #1;
        end
        total++;
        if (rdy[1] !== 1'b1 || bsy[1] !== 1'b0 || dout[1] !== 32'h5A5A0001) begin
            bad++;
            $display("FAIL ws3_resp: rdy=%b bsy=%b dout=%h want 1 0 5a5a0001",
                     rdy[1], bsy[1], dout[1]);
        end
        @(posedge clk); #1;
        req[1] = 1'b0;
        total++;
        if (bsy[1] !== 1'b1 || rdy[1] !== 1'b0) begin
            bad++;
            $display("FAIL ws3_accept_in_resp: bsy=%b rdy=%b want 1 0",
                     bsy[1], rdy[1]);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (rdy[1] !== 1'b1 || dout[1] !== 32'h5A5A0001) begin
            bad++;
            $display("FAIL ws3_second_resp: rdy=%b dout=%h want 1 5a5a0001",
                     rdy[1], dout[1]);
        end
        @(posedge clk); #1;
        total++;
        if (rdy[1] !== 1'b0 || bsy[1] !== 1'b0) begin
            bad++;
            $display("FAIL ws3_single_resp: rdy=%b bsy=%b want 0 0",
                     rdy[1], bsy[1]);
        end
    endtask

    task automatic test_bounds();
        logic [31:0] rd;
        logic e, ok;
        int lat;
        logic        exp_e;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
`ifdef SOC_RAM_BOUNDS_CHECK_EN
        exp_e  = 1'b1;
        exp_hi = 32'h0;
        exp_lo = 32'h0BADF00D;
`else
        exp_e  = 1'b0;
        exp_hi = 32'h12345678;
        exp_lo = 32'h12345678;
`endif
        txn(0, 1'b1, 4'hF, 32'h0, 32'h0BADF00D, rd, e, lat, ok);
        txn(0, 1'b1, 4'hF, 32'h4000, 32'h12345678, rd, e, lat, ok);
        total++;
        if (ok !== 1'b1 || e !== exp_e) begin
            bad++;
            $display("FAIL oor_wr_err: ok=%b err=%b want 1 %b", ok, e, exp_e);
        end
        txn(0, 1'b0, 4'h0, 32'h4000, 32'h0, rd, e, lat, ok);
        total++;
        if (e !== exp_e || rd !== exp_hi) begin
            bad++;
            $display("FAIL oor_rd: err=%b data=%h want %b %h", e, rd, exp_e, exp_hi);
        end
        txn(0, 1'b0, 4'h0, 32'h0, 32'h0, rd, e, lat, ok);
        total++;
        if (e !== 1'b0 || rd !== exp_lo) begin
            bad++;
            $display("FAIL oor_word0: err=%b data=%h want 0 %h", e, rd, exp_lo);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic e, ok;
        int lat;
        txn(2, 1'b1, 4'hF, 32'h30, 32'h0, rd, e, lat, ok);
        total++;
        if (ok !== 1'b1 || lat != 2) begin
            bad++;
            $display("FAIL ws2_wr_lat: ok=%b lat=%0d want 1 2", ok, lat);
        end
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF;
        addr[2] = 32'h30; din[2] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        req[2] = 1'b0;
        total++;
        if (bsy[2] !== 1'b1) begin
            bad++;
            $display("FAIL midrst_busy_before: got %b want 1", bsy[2]);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (rdy[2] !== 1'b0 || bsy[2] !== 1'b0 || err[2] !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async: rdy/bsy/err=%b%b%b want 000",
                     rdy[2], bsy[2], err[2]);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        txn(2, 1'b0, 4'h0, 32'h30, 32'h0, rd, e, lat, ok);
        total++;
        if (ok !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL midrst_mem: ok=%b data=%h want 1 0", ok, rd);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_wait_states();
        test_bounds();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
